// File: rtl/fifo_duth_flex.sv
// ----------------------------------------------------------------------------
// fifo_duth_flex
//
// Circular-buffer FIFO with arbitrary depth (binary pointers that wrap at
// RAM_DEPTH-1, so non-power-of-two depths work), a registered occupancy
// count, almost-full/almost-empty decodes, synchronous flush, optional
// zero-latency bypass and sticky overflow/underflow flags.
//
// Handshake: a write transfers on a rising clk edge when push && ready;
// a read transfers when pop && valid. ready and valid never depend on the
// partner request in the same cycle, except that with BYPASS=1 valid
// follows push while the FIFO is empty. A request made without the
// matching ready/valid is not an error for the partner; it only raises the
// corresponding sticky flag and leaves the contents unchanged.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   flush            synchronous clear of contents and pointers
//   push_data, push  write data / write request
//   ready            FIFO can accept a write
//   pop_data, valid  head-of-queue data / head is valid
//   pop              read request
//   count            number of stored entries
//   almost_full      count >= AF_THRESH
//   almost_empty     count <= AE_THRESH
//   overflow         sticky: push attempted while ready=0
//   underflow        sticky: pop attempted while valid=0
//   clear_err        clears overflow/underflow (a same-cycle set wins)
// ----------------------------------------------------------------------------
module fifo_duth_flex #(
    parameter int DATA_WIDTH = 16,
    parameter int RAM_DEPTH  = 4,
    parameter int AF_THRESH  = RAM_DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter bit BYPASS     = 1'b0,
    localparam int CW        = $clog2(RAM_DEPTH + 1),
    localparam int PW        = $clog2(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  valid,
    input  logic                  pop,
    output logic [CW-1:0]         count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clear_err
);

    localparam logic [PW-1:0] PTR_LAST = PW'(RAM_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RAM_DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic empty;
    logic bypass_xfer;
    logic push_acc;
    logic pop_acc;
    logic ovf_set;
    logic unf_set;

    assign empty = (count_q == '0);
    assign ready = (count_q != CNT_FULL);
    assign valid = !empty || (BYPASS && push);

    // With bypass, a push and pop meeting at an empty FIFO hand the word
    // straight across; storage, pointers and count are left alone.
    assign bypass_xfer = BYPASS && empty && push && pop;

    assign push_acc = push && ready && !flush && !bypass_xfer;
    assign pop_acc  = pop  && valid && !flush && !bypass_xfer;

    assign ovf_set = push && !ready && !flush;
    assign unf_set = pop  && !valid && !flush;

    assign pop_data = (BYPASS && empty) ? push_data : mem_q[rd_ptr_q];

    assign count        = count_q;
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= AE_LVL);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Explicit wrap compare keeps non-power-of-two depths correct.
            if (push_acc) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push_acc && !pop_acc) begin
                count_d = count_q + 1'b1;
            end else if (pop_acc && !push_acc) begin
                count_d = count_q - 1'b1;
            end
        end

        // Set has priority over clear_err so no error event is lost.
        if (clear_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (ovf_set) begin
            overflow_d = 1'b1;
        end
        if (unf_set) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; contents are qualified by count.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_fifo_duth_flex.sv
// ----------------------------------------------------------------------------
// tb_fifo_duth_flex
//
// Directed bench for fifo_duth_flex with three instances:
//   a_*: RAM_DEPTH=5, defaults (AF=4, AE=1), BYPASS=0
//   b_*: RAM_DEPTH=4, AF=3, AE=1, BYPASS=0 (threshold decodes)
//   c_*: RAM_DEPTH=4, BYPASS=1 (fall-through)
// Inputs change 1 time unit after the rising edge; outputs are checked
// there too, well away from the next active edge.
// ----------------------------------------------------------------------------
module tb_fifo_duth_flex;

    logic clk;
    logic rst;

    int n_assert;
    int n_fail;

    // Instance A
    logic        a_flush, a_push, a_pop, a_clear;
    logic [15:0] a_din, a_dout;
    logic        a_ready, a_valid, a_af, a_ae, a_ovf, a_unf;
    logic [2:0]  a_count;

    // Instance B
    logic        b_flush, b_push, b_pop, b_clear;
    logic [15:0] b_din, b_dout;
    logic        b_ready, b_valid, b_af, b_ae, b_ovf, b_unf;
    logic [2:0]  b_count;

    // Instance C
    logic        c_flush, c_push, c_pop, c_clear;
    logic [15:0] c_din, c_dout;
    logic        c_ready, c_valid, c_af, c_ae, c_ovf, c_unf;
    logic [2:0]  c_count;

    fifo_duth_flex #(.DATA_WIDTH(16), .RAM_DEPTH(5)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush), .push_data(a_din), .push(a_push),
        .ready(a_ready), .pop_data(a_dout), .valid(a_valid), .pop(a_pop),
        .count(a_count), .almost_full(a_af), .almost_empty(a_ae),
        .overflow(a_ovf), .underflow(a_unf), .clear_err(a_clear)
    );

    fifo_duth_flex #(.DATA_WIDTH(16), .RAM_DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush), .push_data(b_din), .push(b_push),
        .ready(b_ready), .pop_data(b_dout), .valid(b_valid), .pop(b_pop),
        .count(b_count), .almost_full(b_af), .almost_empty(b_ae),
        .overflow(b_ovf), .underflow(b_unf), .clear_err(b_clear)
    );

    fifo_duth_flex #(.DATA_WIDTH(16), .RAM_DEPTH(4), .BYPASS(1'b1)) dut_c (
        .clk(clk), .rst(rst), .flush(c_flush), .push_data(c_din), .push(c_push),
        .ready(c_ready), .pop_data(c_dout), .valid(c_valid), .pop(c_pop),
        .count(c_count), .almost_full(c_af), .almost_empty(c_ae),
        .overflow(c_ovf), .underflow(c_unf), .clear_err(c_clear)
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        a_flush = 0; a_push = 0; a_pop = 0; a_clear = 0; a_din = '0;
        b_flush = 0; b_push = 0; b_pop = 0; b_clear = 0; b_din = '0;
        c_flush = 0; c_push = 0; c_pop = 0; c_clear = 0; c_din = '0;

        // ---------------- Reset values ----------------
        tick();
        tick();
        chk("rst_count", 32'(a_count), 0);
        chk("rst_ready", 32'(a_ready), 1);
        chk("rst_valid", 32'(a_valid), 0);
        chk("rst_af",    32'(a_af),    0);
        chk("rst_ae",    32'(a_ae),    1);
        chk("rst_ovf",   32'(a_ovf),   0);
        chk("rst_unf",   32'(a_unf),   0);
        rst = 1'b0;
        tick();

        // ---------------- A: fill to full, overflow ----------------
        for (int i = 0; i < 5; i++) begin
            a_push = 1'b1;
            a_din  = 16'(i);
            #1;
            if (i == 0) chk("a_valid_before_first_push", 32'(a_valid), 0);
            tick();
            chk("a_fill_count", 32'(a_count), 32'(i + 1));
            chk("a_fill_valid", 32'(a_valid), 1);
        end
        chk("a_full_ready", 32'(a_ready), 0);
        chk("a_full_af",    32'(a_af),    1);
        chk("a_full_ae",    32'(a_ae),    0);
        a_din = 16'h00AA;
        tick();
        chk("a_ovf_set",    32'(a_ovf),   1);
        chk("a_ovf_count",  32'(a_count), 5);
        a_push = 1'b0;

        // ---------------- A: drain, order check ----------------
        for (int i = 0; i < 5; i++) begin
            a_pop = 1'b1;
            #1;
            chk("a_drain_data", 32'(a_dout), 32'(i));
            tick();
            chk("a_drain_count", 32'(a_count), 32'(4 - i));
            if (i == 0) chk("a_ready_after_pop", 32'(a_ready), 1);
        end
        a_pop = 1'b0;
        chk("a_empty_valid", 32'(a_valid), 0);
        chk("a_empty_ae",    32'(a_ae),    1);

        // ---------------- A: sustained push+pop at count=2 ----------------
        a_push = 1'b1;
        a_din = 16'h0100; tick();
        a_din = 16'h0101; tick();
        chk("a_prime_count", 32'(a_count), 2);
        a_pop = 1'b1;
        for (int k = 0; k < 20; k++) begin
            a_din = 16'(16'h0102 + k);
            #1;
            chk("a_stream_data", 32'(a_dout), 32'(16'h0100 + k));
            tick();
            chk("a_stream_count", 32'(a_count), 2);
        end
        a_push = 1'b0;
        #1; chk("a_tail0", 32'(a_dout), 32'h0114); tick();
        #1; chk("a_tail1", 32'(a_dout), 32'h0115); tick();
        a_pop = 1'b0;
        chk("a_tail_count", 32'(a_count), 0);

        // ---------------- A: error flags ----------------
        a_clear = 1'b1; tick(); a_clear = 1'b0;
        chk("a_ovf_cleared", 32'(a_ovf), 0);
        a_pop = 1'b1; tick();
        chk("a_unf_set", 32'(a_unf), 1);
        a_clear = 1'b1; tick();
        chk("a_unf_set_wins", 32'(a_unf), 1);
        a_pop = 1'b0; tick();
        a_clear = 1'b0;
        chk("a_unf_cleared", 32'(a_unf), 0);

        // ---------------- A: flush with push/pop ----------------
        a_push = 1'b1;
        a_din = 16'h0031; tick();
        a_din = 16'h0032; tick();
        a_din = 16'h0033; tick();
        chk("a_preflush_count", 32'(a_count), 3);
        a_flush = 1'b1; a_pop = 1'b1; a_din = 16'h0099;
        tick();
        a_flush = 1'b0; a_pop = 1'b0; a_push = 1'b0;
        chk("a_flush_count", 32'(a_count), 0);
        chk("a_flush_valid", 32'(a_valid), 0);
        chk("a_flush_ovf",   32'(a_ovf),   0);
        chk("a_flush_unf",   32'(a_unf),   0);
        a_push = 1'b1; a_din = 16'h0077; tick(); a_push = 1'b0;
        chk("a_postflush_count", 32'(a_count), 1);
        chk("a_postflush_data",  32'(a_dout),  32'h0077);

        // ---------------- Asynchronous reset mid-operation ----------------
        #2;
        rst = 1'b1;
        #1;
        chk("a_async_rst_count", 32'(a_count), 0);
        chk("a_async_rst_valid", 32'(a_valid), 0);
        tick();
        rst = 1'b0;
        tick();
        a_push = 1'b1; a_din = 16'h005A; tick(); a_push = 1'b0;
        chk("a_after_rst_count", 32'(a_count), 1);
        chk("a_after_rst_data",  32'(a_dout),  32'h005A);

        // ---------------- B: threshold decodes over counts 0..4 ----------------
        for (int i = 0; i < 5; i++) begin
            chk("b_count", 32'(b_count), 32'(i));
            chk("b_ae", 32'(b_ae), (i <= 1) ? 32'd1 : 32'd0);
            chk("b_af", 32'(b_af), (i >= 3) ? 32'd1 : 32'd0);
            if (i < 4) begin
                b_push = 1'b1; b_din = 16'(16'h0B00 + i); tick(); b_push = 1'b0;
            end
        end
        chk("b_full_ready", 32'(b_ready), 0);

        // ---------------- C: bypass ----------------
        c_push = 1'b1; c_pop = 1'b1; c_din = 16'h1234;
        #1;
        chk("c_byp_valid", 32'(c_valid), 1);
        chk("c_byp_data",  32'(c_dout),  32'h1234);
        tick();
        chk("c_byp_count", 32'(c_count), 0);
        chk("c_byp_ovf",   32'(c_ovf),   0);
        chk("c_byp_unf",   32'(c_unf),   0);
        c_pop = 1'b0; c_din = 16'h0055;
        #1;
        chk("c_fall_valid", 32'(c_valid), 1);
        tick();
        c_push = 1'b0;
        chk("c_push_count", 32'(c_count), 1);
        chk("c_push_data",  32'(c_dout),  32'h0055);
        chk("c_push_valid", 32'(c_valid), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_duth_flex.md
# fifo_duth_flex

Parametrised circular-buffer FIFO, next generation of the team's one-hot FIFO. Adds arbitrary depth (binary pointers, non-power-of-two allowed), occupancy count, almost-full/almost-empty thresholds, synchronous flush, optional zero-latency bypass, and sticky overflow/underflow flags instead of simulation-fatal checks. Used as the general elastic buffer between AXI and AHB channel stages, where the credit logic needs occupancy information.

## Interface
- DATA_WIDTH, 16, payload width in bits
- RAM_DEPTH, 4, number of slots, legal range ≥2, any integer
- AF_THRESH, RAM_DEPTH-1, almost_full asserts when count ≥ AF_THRESH, legal range 1..RAM_DEPTH
- AE_THRESH, 1, almost_empty asserts when count ≤ AE_THRESH, legal range 0..RAM_DEPTH-1
- BYPASS, 0, 1 = fall-through: a push into an empty FIFO is visible on pop_data in the same cycle
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous clear of all contents
- push_data  in  DATA_WIDTH  write data
- push  in  1  write request
- ready  out  1  FIFO can accept a write
- pop_data  out  DATA_WIDTH  head-of-queue data
- valid  out  1  pop_data is valid
- pop  in  1  read request
- count  out  $clog2(RAM_DEPTH+1)  number of stored entries
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- overflow  out  1  sticky: a push was attempted while ready=0
- underflow  out  1  sticky: a pop was attempted while valid=0
- clear_err  in  1  clears overflow and underflow

## Operation
- Storage: RAM_DEPTH × DATA_WIDTH registers, not reset. Binary wr_ptr and rd_ptr in 0..RAM_DEPTH-1; each wraps from RAM_DEPTH-1 to 0, with no power-of-two assumption. count is a registered counter.
- Accepted push: push & ready & !flush. Writes mem[wr_ptr] and advances wr_ptr.
- Accepted pop: pop & valid & !flush. Advances rd_ptr.
- ready = (count != RAM_DEPTH). Registered-derived; it does not depend on pop in the same cycle. A push while full is rejected even if a pop occurs in that cycle.
- valid = (count != 0), OR'd with push when BYPASS=1.
- pop_data: combinational mux of mem[rd_ptr]. With BYPASS=1 and count=0, pop_data = push_data.
- Bypass transfer (BYPASS=1, count=0, push & pop):
  - No write, no pointer movement, count unchanged.
  - Neither flag is set.
- BYPASS=1, count=0, push without pop: a normal write.
- count update:
  - +1 on an accepted push without an accepted pop.
  - −1 on an accepted pop without an accepted push.
  - Unchanged when both or neither are accepted.
- Rejected requests (flush=0):
  - push & !ready sets overflow; no state change.
  - pop & !valid sets underflow; no state change.
- Flag priority: on a same-cycle set and clear_err, set wins.
- Flush:
  - Next cycle: wr_ptr=rd_ptr=0, count=0.
  - push and pop in the flush cycle are ignored and flag nothing.
  - Flush does not clear the error flags.
- almost_full and almost_empty are decoded combinationally from the count register only.

## Timing
- Reset values: count=0, ready=1, valid=0 (BYPASS=1: valid=push), almost_full=0, almost_empty=1, overflow=0, underflow=0.
- pop_data is don't-care whenever valid=0.
- Push-to-valid latency: 1 cycle (BYPASS=0); 0 cycles when empty (BYPASS=1).
- Pop-to-ready latency: ready rises the cycle after a pop from full.
- Full throughput: simultaneous accepted push and pop every cycle at any 0<count<RAM_DEPTH sustains 1 transfer per cycle.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). The first push after deassertion lands in slot 0.

## Test plan
- RAM_DEPTH=5: push 0..4 -> ready=0 with count=5; push 0xAA -> overflow=1, count stays 5. Pop 5 times -> data 0,1,2,3,4 in order; wr_ptr wraps 4→0.
- RAM_DEPTH=5: 20 cycles of simultaneous push/pop at count=2 -> count stays 2, output order preserved across pointer wrap.
- Empty FIFO: pop -> underflow=1. clear_err together with another bad pop -> underflow stays 1. clear_err alone -> underflow=0.
- RAM_DEPTH=4, AF_THRESH=3, AE_THRESH=1: counts 0..4 -> almost_empty=1,1,0,0,0 and almost_full=0,0,0,1,1.
- count=3: flush asserted together with push and pop -> next cycle count=0, valid=0, no flags set; the next push lands in slot 0 and reads back correctly.
- BYPASS=1, empty: push 0x1234 with pop -> valid=1 and pop_data=0x1234 in the same cycle, count stays 0. Push 0x55 without pop -> count=1, pop_data=0x55.
